// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default debounce length for the stopwatch controller.
package stopwatch_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUNNING  = 3'd1,
    LAP      = 3'd2,
    STOPPED  = 3'd3,
    OVERFLOW = 3'd4
  } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Raw pushbutton -> 2-flop synchronizer -> counting debouncer -> rising-edge press pulse.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_p2;
  logic             level_p3;
  logic [CNT_W-1:0] cnt_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      level_p2 <= 1'b0;
      level_p3 <= 1'b0;
      cnt_p2   <= '0;
    end else begin
      sync_p0  <= btn;
      sync_p1  <= sync_p0;
      // stage p2: accept the new level on the Nth consecutive differing sample
      if (sync_p1 == level_p2) begin
        cnt_p2 <= '0;
      end else if (cnt_p2 == CNT_LAST) begin
        level_p2 <= sync_p1;
        cnt_p2   <= '0;
      end else if (cnt_p2 < CNT_LAST) begin
        cnt_p2 <= cnt_p2 + 1'b1;
      end
      // stage p3: previous debounced level for edge detection
      level_p3 <= level_p2;
    end
  end

  assign press = level_p2 & ~level_p3;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons and datapath overflow drive run/hold/clear.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       overflow_in,
  output logic       run,
  output logic       hold,
  output logic       clear,
  output logic [2:0] state,
  output logic       overflow_led
);

  logic   ev_ss;
  logic   ev_lap;
  logic   ev_clr;
  state_t state_q;
  state_t state_nxt;
  logic   run_nxt;
  logic   hold_nxt;
  logic   clear_nxt;
  logic   ovf_nxt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
    .clk(CLK_50), .rst(reset), .btn(btn_start_stop), .press(ev_ss)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
    .clk(CLK_50), .rst(reset), .btn(btn_lap), .press(ev_lap)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
    .clk(CLK_50), .rst(reset), .btn(btn_clear), .press(ev_clr)
  );

  // Each branch tests events in priority order, so lower ones are simply dropped.
  always_comb begin
    state_nxt = state_q;
    clear_nxt = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_clr)     clear_nxt = 1'b1;
        else if (ev_ss) state_nxt = RUNNING;
      end
      RUNNING: begin
        if (overflow_in) state_nxt = OVERFLOW;
        else if (ev_ss)  state_nxt = STOPPED;
        else if (ev_lap) state_nxt = LAP;
      end
      LAP: begin
        if (overflow_in) state_nxt = OVERFLOW;
        else if (ev_ss)  state_nxt = STOPPED;
        else if (ev_lap) state_nxt = RUNNING;
      end
      STOPPED: begin
        if (ev_clr) begin
          state_nxt = IDLE;
          clear_nxt = 1'b1;
        end else if (ev_ss) begin
          state_nxt = RUNNING;
        end
      end
      OVERFLOW: begin
        if (ev_clr) begin
          state_nxt = IDLE;
          clear_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    run_nxt  = (state_nxt == RUNNING) || (state_nxt == LAP);
    hold_nxt = (state_nxt == LAP);
    ovf_nxt  = (state_nxt == OVERFLOW);
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      run          <= 1'b0;
      hold         <= 1'b0;
      clear        <= 1'b0;
      overflow_led <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      run          <= run_nxt;
      hold         <= hold_nxt;
      clear        <= clear_nxt;
      overflow_led <= ovf_nxt;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed + randomized bench for stopwatch_ctrl against a sample-window reference model.
module tb_stopwatch_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_ss = 1'b0, b_lap = 1'b0, b_clr = 1'b0, ovf = 1'b0;
  logic       run, hold, clear, ovf_led;
  logic [2:0] state;

  int compared = 0;
  int mismatched = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK_50(clk), .reset(rst), .btn_start_stop(b_ss), .btn_lap(b_lap),
    .btn_clear(b_clr), .overflow_in(ovf), .run(run), .hold(hold),
    .clear(clear), .state(state), .overflow_led(ovf_led)
  );

  always #5 clk = ~clk;

  // Reference model: 0=start_stop, 1=lap, 2=clear.
  // rq delays raw samples by two edges; dh holds the last D synchronized samples.
  bit rq[3][$];
  bit dh[3][$];
  bit lvl[3];
  bit evt[3];
  int m_state;
  bit m_clear;

  int         lap_entries, clear_cnt;
  logic [2:0] prev_state;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      rq[i].delete();
      rq[i].push_back(1'b0);
      rq[i].push_back(1'b0);
      dh[i].delete();
      lvl[i] = 1'b0;
      evt[i] = 1'b0;
    end
    m_state = 0;
    m_clear = 1'b0;
  endfunction

  function automatic void model_edge(bit r0, bit r1, bit r2, bit o);
    bit raw[3];
    int nxt;
    bit diff;
    raw[0] = r0; raw[1] = r1; raw[2] = r2;
    nxt = m_state;
    m_clear = 1'b0;
    if ((m_state == 1 || m_state == 2) && o) nxt = 4;
    else if (evt[2] && m_state != 1 && m_state != 2) begin
      nxt = 0;
      m_clear = 1'b1;
    end
    else if (evt[0] && m_state != 4) nxt = (m_state == 0 || m_state == 3) ? 1 : 3;
    else if (evt[1] && (m_state == 1 || m_state == 2)) nxt = 3 - m_state;
    m_state = nxt;
    for (int i = 0; i < 3; i++) begin
      dh[i].push_back(rq[i].pop_front());
      rq[i].push_back(raw[i]);
      if (dh[i].size() > D) void'(dh[i].pop_front());
      diff = (dh[i].size() == D);
      for (int j = 0; j < dh[i].size(); j++)
        if (dh[i][j] == lvl[i]) diff = 1'b0;
      evt[i] = 1'b0;
      if (diff) begin
        lvl[i] = ~lvl[i];
        evt[i] = lvl[i];
      end
    end
  endfunction

  task automatic cmp(string tag, logic [7:0] obs, logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("state", 8'(state), 8'(m_state));
    cmp("run", 8'(run), 8'(m_state == 1 || m_state == 2));
    cmp("hold", 8'(hold), 8'(m_state == 2));
    cmp("clear", 8'(clear), 8'(m_clear));
    cmp("overflow_led", 8'(ovf_led), 8'(m_state == 4));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(b_ss, b_lap, b_clr, ovf);
    #1;
    check_all();
    if (state !== prev_state && state === 3'd2) lap_entries++;
    if (clear === 1'b1) clear_cnt++;
    prev_state = state;
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic press_ss();
    b_ss = 1'b1; steps(8); b_ss = 1'b0; steps(8);
  endtask

  task automatic press_lap();
    b_lap = 1'b1; steps(8); b_lap = 1'b0; steps(8);
  endtask

  initial begin
    int lat;
    prev_state = 3'd0;
    lap_entries = 0;
    clear_cnt = 0;
    model_reset();

    // Reset state
    steps(3);
    cmp("rst_state", 8'(state), 8'd0);
    cmp("rst_run", 8'(run), 8'd0);
    rst = 1'b0;
    steps(3);

    // start_stop from IDLE, with latency window
    clear_cnt = 0;
    lat = -1;
    b_ss = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      if (i == 11) b_ss = 1'b0;
      step();
      if (lat < 0 && run === 1'b1) lat = i;
    end
    cmp("ss_latency_ok", 8'(lat >= D + 3 && lat <= D + 5), 8'd1);
    cmp("ss_state", 8'(state), 8'd1);
    cmp("ss_run", 8'(run), 8'd1);
    cmp("ss_hold", 8'(hold), 8'd0);
    cmp("ss_no_clear", 8'(clear_cnt), 8'd0);

    // Bouncing lap while RUNNING
    lap_entries = 0;
    for (int k = 0; k < 4; k++) begin
      b_lap = (k % 2 == 0);
      steps(2);
    end
    b_lap = 1'b1; steps(10);
    b_lap = 1'b0; steps(10);
    cmp("lap_one_entry", 8'(lap_entries), 8'd1);
    cmp("lap_state", 8'(state), 8'd2);
    cmp("lap_hold", 8'(hold), 8'd1);
    cmp("lap_run", 8'(run), 8'd1);

    // Back to RUNNING, then overflow
    press_lap();
    cmp("lap_back_running", 8'(state), 8'd1);
    ovf = 1'b1;
    step();
    cmp("ovf_state", 8'(state), 8'd4);
    cmp("ovf_run", 8'(run), 8'd0);
    cmp("ovf_led", 8'(ovf_led), 8'd1);
    press_ss();
    cmp("ovf_ignores_ss", 8'(state), 8'd4);
    clear_cnt = 0;
    b_clr = 1'b1; steps(8); b_clr = 1'b0; steps(8);
    cmp("ovf_clear_pulses", 8'(clear_cnt), 8'd1);
    cmp("ovf_cleared_state", 8'(state), 8'd0);
    ovf = 1'b0;
    steps(2);

    // Simultaneous clear and start_stop while STOPPED
    press_ss();
    press_ss();
    cmp("stopped_state", 8'(state), 8'd3);
    clear_cnt = 0;
    b_clr = 1'b1; b_ss = 1'b1; steps(10);
    b_clr = 1'b0; b_ss = 1'b0; steps(8);
    cmp("simul_state", 8'(state), 8'd0);
    cmp("simul_clear_pulses", 8'(clear_cnt), 8'd1);
    cmp("simul_run", 8'(run), 8'd0);

    // Reset in the middle of a lap debounce while in LAP
    press_ss();
    press_lap();
    cmp("pre_rst_lap", 8'(state), 8'd2);
    b_lap = 1'b1;
    steps(4);
    rst = 1'b1;
    #1;
    model_reset();
    cmp("midrst_state", 8'(state), 8'd0);
    cmp("midrst_run", 8'(run), 8'd0);
    cmp("midrst_hold", 8'(hold), 8'd0);
    cmp("midrst_clear", 8'(clear), 8'd0);
    steps(2);
    b_lap = 1'b0;
    rst = 1'b0;
    steps(10);

    // start_stop held through reset release yields one press
    b_ss = 1'b1;
    rst = 1'b1;
    steps(3);
    rst = 1'b0;
    steps(14);
    b_ss = 1'b0;
    steps(8);
    cmp("held_thru_rst", 8'(state), 8'd1);

    // Randomized phase
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) b_ss = ~b_ss;
      if ($urandom_range(0, 5) == 0) b_lap = ~b_lap;
      if ($urandom_range(0, 7) == 0) b_clr = ~b_clr;
      if ($urandom_range(0, 24) == 0) ovf = ~ovf;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
